transmitter: RTL

TRANSMITTER -- requirements
Module: transmitter

---
 rtl/uart_pkg.sv | 36 +++
 rtl/transmitter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//
// Contents:
//   uart_state_e   frame FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   DATA_BITS      data bits per frame
//   BIT_IDX_W      width of the data-bit index
//   LINE_IDLE      serial line level between frames
//   START_BIT      serial line level of the start bit
//   STOP_BIT       serial line level of the stop bit
//   parity_of()    even/odd parity of one data byte
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS = 8;
    localparam int   BIT_IDX_W = $clog2(DATA_BITS);

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Even parity is the XOR of all data bits; odd parity is its inverse.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] b,
                                       input logic                 odd);
        return (^b) ^ odd;
    endfunction

endpackage

// File: rtl/transmitter.sv
// ----------------------------------------------------------------------------
// transmitter -- UART transmitter, one serial bit per rising clock edge.
//
// Frame: start bit (0), data[0]..data[7] LSB first, optional parity bit,
// stop bit (1). A one-byte holding register decouples the request side from
// the frame in progress, so a byte accepted before a stop bit goes out
// immediately after it with no idle bit in between.
//
// Parameters:
//   PARITY_EN   1 inserts a parity bit after data bit 7
//   PARITY_ODD  0 even parity, 1 odd parity (ignored when PARITY_EN=0)
//
// Ports:
//   clk_115200hz  in   bit clock, one serial bit period per rising edge
//   reset_n       in   asynchronous active-low reset
//   data[7:0]     in   byte to transmit, sampled on accept
//   send          in   transmit request
//   ready         out  holding register empty
//   out           out  serial line, idle high, registered
//   busy          out  a frame is on the line (START through STOP)
//   done          out  high exactly while out carries the stop bit
//   state_dbg     out  current FSM state, for observation only
//
// Handshake: a byte is accepted on a rising edge where send=1 and ready=1.
// ready depends only on holding-register occupancy; send while ready=0 is
// ignored and the held byte is left untouched.
// ----------------------------------------------------------------------------
module transmitter
    import uart_pkg::*;
#(
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk_115200hz,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 send,
    output logic                 ready,
    output logic                 out,
    output logic                 busy,
    output logic                 done,
    output uart_state_e          state_dbg
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e            state;
    logic [DATA_BITS-1:0]   hold_data;
    logic                   hold_valid;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [BIT_IDX_W-1:0]   bit_idx;
    logic [BIT_IDX_W-1:0]   next_idx;
    logic                   drain;

    assign ready     = ~hold_valid;
    assign state_dbg = state;
    assign next_idx  = bit_idx + 1'b1;

    // The holding register empties into the shift register whenever the FSM
    // enters START, which happens only from IDLE or STOP. Because drain needs
    // hold_valid=1 and accept needs ready=1, the two never share an edge.
    assign drain = hold_valid && ((state == ST_IDLE) || (state == ST_STOP));

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_115200hz or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end else if (send && ready) begin
            hold_data  <= data;
            hold_valid <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with registered line, busy and done outputs. Each branch
    // sets the outputs for the state being entered, so out/busy/done always
    // describe the bit currently on the line.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_115200hz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            out       <= LINE_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (hold_valid) begin
                        state     <= ST_START;
                        out       <= START_BIT;
                        busy      <= 1'b1;
                        shift_reg <= hold_data;
                    end else begin
                        out  <= LINE_IDLE;
                        busy <= 1'b0;
                    end
                end

                ST_START: begin
                    state   <= ST_DATA;
                    bit_idx <= '0;
                    out     <= shift_reg[0];
                end

                ST_DATA: begin
                    if (bit_idx == LAST_IDX) begin
                        bit_idx <= '0;
                        if (PARITY_EN) begin
                            state <= ST_PARITY;
                            out   <= parity_of(shift_reg, PARITY_ODD);
                        end else begin
                            state <= ST_STOP;
                            out   <= STOP_BIT;
                            done  <= 1'b1;
                        end
                    end else begin
                        bit_idx <= next_idx;
                        out     <= shift_reg[next_idx];
                    end
                end

                ST_PARITY: begin
                    state <= ST_STOP;
                    out   <= STOP_BIT;
                    done  <= 1'b1;
                end

                ST_STOP: begin
                    done <= 1'b0;
                    if (hold_valid) begin
                        // Back-to-back: next start bit follows the stop bit.
                        state     <= ST_START;
                        out       <= START_BIT;
                        shift_reg <= hold_data;
                    end else begin
                        state <= ST_IDLE;
                        out   <= LINE_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    out   <= LINE_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
